// File: rtl/eucl_seq_core_if.sv
// Instruction handshake bundle for eucl_seq_core: request side (valid/instr)
// and completion side (ready/done/illegal).
interface eucl_seq_core_if #(
  parameter int DW = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [4+3*DW-1:0] instr;
  logic              done;
  logic              illegal;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    input  done,
    input  illegal
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    output done,
    output illegal
  );
endinterface

// File: rtl/eucl_seq_core.sv
// Multi-cycle instruction sequencer: IDLE -> (RD -> EX ->) WB with an internal
// register file, ALU, program counter and {cmp, zero, so, carry} flags.
module eucl_seq_core #(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int PCW = 5
) (
  input  logic              clk,
  input  logic              rst,
  eucl_seq_core_if.slave    bus,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data,
  output logic [PCW-1:0]    prog_counter,
  output logic [3:0]        flags
);

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_e;
  typedef enum logic [3:0] {
    OP_LOAD = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_INC = 4'd3, OP_CMP = 4'd4,
    OP_MOV  = 4'd5, OP_JMP = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8, OP_JZ  = 4'd9
  } op_e;

  state_e         state, state_nxt;
  logic [3:0]     opc;
  logic [DW-1:0]  op1, op2, op3;
  logic [DW-1:0]  regs [2**AW];
  logic [DW-1:0]  opa, opb, opd;
  logic [DW-1:0]  alu_res, ex_res;
  logic [3:0]     alu_flags, ex_flags;
  logic [DW:0]    wide;
  logic [3:0]     in_opc;
  logic           in_alu;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [3:0]     flags_nxt;
  logic [PCW-1:0] pc_nxt;

  // Operand bits above the register/PC index widths are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{op1, op3};

  assign in_opc   = bus.instr[4+3*DW-1 -: 4];
  assign in_alu   = in_opc inside {OP_ADD, OP_SUB, OP_INC, OP_CMP, OP_SHL, OP_SHR};
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = in_alu ? RD : WB;
      end
      RD:  state_nxt = EX;
      EX:  state_nxt = WB;
      WB: begin
        bus.done    = 1'b1;
        bus.illegal = (opc >= 4'd10);
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU evaluates in EX on operands captured in RD; untouched flags pass through.
  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_flags = flags;
    case (opc)
      OP_ADD, OP_SUB, OP_INC: begin
        if (opc == OP_ADD)      wide = {1'b0, opa} + {1'b0, opb};
        else if (opc == OP_SUB) wide = {1'b0, opa} - {1'b0, opb};
        else                    wide = {1'b0, opd} + {{DW{1'b0}}, 1'b1};
        alu_res      = wide[DW-1:0];
        alu_flags[0] = wide[DW];
        alu_flags[2] = (alu_res == '0);
      end
      OP_CMP: alu_flags[3] = (opa >= opb);
      OP_SHL: begin
        alu_res      = {opa[DW-2:0], 1'b0};
        alu_flags[1] = opa[DW-1];
        alu_flags[2] = (alu_res == '0);
      end
      OP_SHR: begin
        alu_res      = {1'b0, opa[DW-1:1]};
        alu_flags[1] = opa[0];
        alu_flags[2] = (alu_res == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = op1[AW-1:0];
    wr_data   = ex_res;
    flags_nxt = flags;
    pc_nxt    = prog_counter + PCW'(1);
    case (opc)
      OP_LOAD: begin
        wr_en   = 1'b1;
        wr_data = op2;
      end
      OP_ADD, OP_SUB, OP_INC, OP_SHL, OP_SHR: begin
        wr_en     = 1'b1;
        flags_nxt = ex_flags;
      end
      OP_CMP: flags_nxt = ex_flags;
      OP_MOV: begin
        wr_en   = 1'b1;
        wr_addr = op2[AW-1:0];
        wr_data = regs[op1[AW-1:0]];
      end
      OP_JMP: pc_nxt = op1[PCW-1:0];
      OP_JZ:  if (flags[2]) pc_nxt = op1[PCW-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_counter <= '0;
      flags        <= '0;
      opc          <= '0;
      op1          <= '0;
      op2          <= '0;
      op3          <= '0;
      opa          <= '0;
      opb          <= '0;
      opd          <= '0;
      ex_res       <= '0;
      ex_flags     <= '0;
      for (int unsigned i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && bus.instr_valid) {opc, op1, op2, op3} <= bus.instr;
      if (state == RD) begin
        opa <= regs[op2[AW-1:0]];
        opb <= regs[op3[AW-1:0]];
        opd <= regs[op1[AW-1:0]];
      end
      if (state == EX) begin
        ex_res   <= alu_res;
        ex_flags <= alu_flags;
      end
      if (state == WB) begin
        prog_counter <= pc_nxt;
        flags        <= flags_nxt;
        if (wr_en) regs[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_eucl_seq_core.sv
// Directed bench for eucl_seq_core: hand-computed results, flags, PC and latency.
module tb_eucl_seq_core;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [4:0] pc;
  logic [3:0] flags;
  int         passed = 0;
  int         total  = 0;
  int         lat;
  logic       ill;
  logic [7:0] dbg_wb;

  eucl_seq_core_if #(.DW(8)) bus();

  eucl_seq_core #(.DW(8), .AW(5), .PCW(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .prog_counter(pc), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Issue one instruction, scramble instr after acceptance, wait for done (bounded).
  task automatic send(input logic [3:0] op, input logic [7:0] a, b, c,
                      output int l, output logic il, output logic [7:0] dwb);
    int n = 0;
    while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    bus.instr       = {op, a, b, c};
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = '1;
    l = 1;
    while (!bus.done && l < 10) begin @(posedge clk); #1; l++; end
    il  = bus.illegal;
    dwb = dbg_data;
    @(posedge clk); #1;
  endtask

  logic [7:0] v;

  initial begin
    rst = 1'b1; bus.instr_valid = 1'b0; bus.instr = '0; dbg_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    rd(5'd3, v); chk("rst_r3", v, 0);

    dbg_addr = 5'd3;
    send(4'h0, 8'd3, 8'hA5, 8'h00, lat, ill, dbg_wb);
    chk("load_lat", lat, 1);
    chk("load_wb_prewrite", dbg_wb, 8'h00);
    chk("load_illegal", ill, 0);
    rd(5'd3, v); chk("load_r3", v, 8'hA5);
    chk("load_pc", pc, 1);
    chk("load_flags", flags, 0);

    send(4'h0, 8'd1, 8'hF0, 8'h00, lat, ill, dbg_wb);
    send(4'h0, 8'd2, 8'h20, 8'h00, lat, ill, dbg_wb);
    send(4'h1, 8'd4, 8'd1, 8'd2, lat, ill, dbg_wb);
    chk("add_lat", lat, 3);
    rd(5'd4, v); chk("add_r4", v, 8'h10);
    chk("add_flags", flags, 4'b0001);
    chk("add_pc", pc, 4);

    send(4'h2, 8'd5, 8'd2, 8'd1, lat, ill, dbg_wb);
    rd(5'd5, v); chk("sub_r5", v, 8'h30);
    chk("sub_flags", flags, 4'b0001);
    send(4'h2, 8'd6, 8'd1, 8'd1, lat, ill, dbg_wb);
    rd(5'd6, v); chk("sub0_r6", v, 8'h00);
    chk("sub0_flags", flags, 4'b0100);

    send(4'h4, 8'd4, 8'd2, 8'd1, lat, ill, dbg_wb);
    chk("cmp_lat", lat, 3);
    chk("cmp_lt_flags", flags, 4'b0100);
    rd(5'd4, v); chk("cmp_r4_kept", v, 8'h10);
    send(4'h4, 8'd4, 8'd1, 8'd2, lat, ill, dbg_wb);
    chk("cmp_ge_flags", flags, 4'b1100);
    chk("cmp_pc", pc, 8);

    send(4'h0, 8'd8, 8'h81, 8'h00, lat, ill, dbg_wb);
    send(4'h7, 8'd9, 8'd8, 8'h00, lat, ill, dbg_wb);
    rd(5'd9, v); chk("shl_r9", v, 8'h02);
    chk("shl_flags", flags, 4'b1010);
    send(4'h0, 8'd10, 8'h01, 8'h00, lat, ill, dbg_wb);
    send(4'h8, 8'd11, 8'd10, 8'h00, lat, ill, dbg_wb);
    rd(5'd11, v); chk("shr_r11", v, 8'h00);
    chk("shr_flags", flags, 4'b1110);
    chk("shr_pc", pc, 12);

    send(4'h9, 8'h07, 8'h00, 8'h00, lat, ill, dbg_wb);
    chk("jz_taken_lat", lat, 1);
    chk("jz_taken_pc", pc, 7);
    send(4'h3, 8'd10, 8'h00, 8'h00, lat, ill, dbg_wb);
    rd(5'd10, v); chk("inc_r10", v, 8'h02);
    chk("inc_flags", flags, 4'b1010);
    send(4'h9, 8'h07, 8'h00, 8'h00, lat, ill, dbg_wb);
    chk("jz_not_taken_pc", pc, 9);

    send(4'h0, 8'd12, 8'hFF, 8'h00, lat, ill, dbg_wb);
    send(4'h3, 8'd12, 8'h00, 8'h00, lat, ill, dbg_wb);
    rd(5'd12, v); chk("inc_ovf_r12", v, 8'h00);
    chk("inc_ovf_flags", flags, 4'b1111);

    dbg_addr = 5'd13;
    send(4'h5, 8'd1, 8'd13, 8'h00, lat, ill, dbg_wb);
    chk("mov_lat", lat, 1);
    rd(5'd13, v); chk("mov_r13", v, 8'hF0);
    chk("mov_pc", pc, 12);

    dbg_addr = 5'd2;
    send(4'h1, 8'd2, 8'd2, 8'd2, lat, ill, dbg_wb);
    chk("alias_wb_prewrite", dbg_wb, 8'h20);
    rd(5'd2, v); chk("alias_r2", v, 8'h40);
    chk("alias_flags", flags, 4'b1010);

    send(4'h6, 8'h1F, 8'h00, 8'h00, lat, ill, dbg_wb);
    chk("jmp_pc", pc, 31);
    send(4'h0, 8'd14, 8'h55, 8'h00, lat, ill, dbg_wb);
    chk("wrap_pc", pc, 0);
    rd(5'd14, v); chk("wrap_r14", v, 8'h55);

    send(4'hC, 8'd15, 8'h77, 8'h00, lat, ill, dbg_wb);
    chk("illegal_lat", lat, 1);
    chk("illegal_pulse", ill, 1);
    chk("illegal_pc", pc, 1);
    chk("illegal_flags", flags, 4'b1010);
    rd(5'd15, v); chk("illegal_nowrite", v, 8'h00);

    // Reset lands while ADD r7 sits in EX.
    bus.instr = {4'h1, 8'd7, 8'd1, 8'd2};
    bus.instr_valid = 1'b1;
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_ready", bus.instr_ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_pc", pc, 0);
    chk("abort_flags", flags, 0);
    rd(5'd7, v); chk("abort_r7", v, 8'h00);
    rd(5'd1, v); chk("abort_r1_cleared", v, 8'h00);
    @(posedge clk); #1;
    rd(5'd7, v); chk("abort_r7_later", v, 8'h00);

    send(4'h0, 8'd3, 8'h5A, 8'h00, lat, ill, dbg_wb);
    rd(5'd3, v); chk("post_rst_r3", v, 8'h5A);
    chk("post_rst_pc", pc, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
